// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the compress1 FSM state type.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;

    // round(2x/Q) mod 2 is 1 exactly for KYBER_TH_LO <= x <= KYBER_TH_HI
    localparam logic [15:0] KYBER_TH_LO = 16'd833;
    localparam logic [15:0] KYBER_TH_HI = 16'd2496;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_OUT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/compress1_if.sv
// Handshake/data bundle between a coefficient producer/byte consumer and compress1.
interface compress1_if;

    logic        set;
    logic        readin;
    logic        full_in;
    logic [15:0] comp_din_1;
    logic [15:0] comp_din_2;
    logic [7:0]  in_index;
    logic        readout;
    logic        readin_ok;
    logic [7:0]  comp_dout;
    logic [7:0]  out_index;
    logic        readout_ok;
    logic        done;
    logic        err;

    modport master (
        output set, readin, full_in, comp_din_1, comp_din_2, in_index, readout,
        input  readin_ok, comp_dout, out_index, readout_ok, done, err
    );

    modport slave (
        input  set, readin, full_in, comp_din_1, comp_din_2, in_index, readout,
        output readin_ok, comp_dout, out_index, readout_ok, done, err
    );

endinterface

// File: rtl/compress1_bit.sv
// Combinational 1-bit compression of one coefficient, plus an out-of-range flag.
// The flag logic exists only when COMPRESS1_RANGE_CHECK_EN is defined.
module compress1_bit
    import kyber_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic [15:0] coef,
    output logic        bit_out,
    output logic        over_q
);

    // Non-Kyber moduli fall back to thresholds derived from Q/4 and 3Q/4.
    localparam logic [15:0] TH_LO = (Q == KYBER_Q) ? KYBER_TH_LO : 16'((Q + 3) / 4);
    localparam logic [15:0] TH_HI = (Q == KYBER_Q) ? KYBER_TH_HI : 16'((3 * Q - 1) / 4);

    assign bit_out = (coef >= TH_LO) && (coef <= TH_HI);

`ifdef COMPRESS1_RANGE_CHECK_EN
    assign over_q = (coef >= 16'(Q));
`else
    assign over_q = 1'b0;
`endif

endmodule

// File: rtl/compress1.sv
// compress1: packs 1-bit-compressed coefficient pairs into a buffer, then
// streams it out LSB-first as bytes. Optional macro COMPRESS1_RANGE_CHECK_EN
// enables the sticky err flag for coefficients >= Q.
module compress1
    import kyber_pkg::*;
#(
    parameter int N_COEF = KYBER_N,
    parameter int Q      = KYBER_Q
) (
    input  logic      clk,
    input  logic      reset,
    compress1_if.slave bus
);

    localparam int N_BYTES = N_COEF / 8;
    localparam int BYTE_W  = $clog2(N_BYTES);
    localparam int BUF_W   = $clog2(N_COEF);
    localparam int PAIR_W  = BUF_W - 1;
    localparam logic [8:0] N_PAIRS = 9'(N_COEF / 2);

    state_t              state;
    state_t              state_nx;
    logic [N_COEF-1:0]   buffer;
    logic [BYTE_W-1:0]   byte_idx;
    logic                err_q;
    logic                bit_1, bit_2, range_1, range_2;
    logic                xfer, rd_xfer, in_range, last_byte, load_entry;
    logic [BUF_W-1:0]    pos_1, pos_2;

    compress1_bit #(.Q(Q)) u_bit_1 (.coef(bus.comp_din_1), .bit_out(bit_1), .over_q(range_1));
    compress1_bit #(.Q(Q)) u_bit_2 (.coef(bus.comp_din_2), .bit_out(bit_2), .over_q(range_2));

    assign xfer       = bus.readin && (state == ST_LOAD);
    assign rd_xfer    = bus.readout && (state == ST_OUT);
    assign load_entry = (state == ST_IDLE) && bus.set;
    assign in_range   = ({1'b0, bus.in_index} < N_PAIRS);
    assign last_byte  = (byte_idx == BYTE_W'(N_BYTES - 1));
    assign pos_1      = {bus.in_index[PAIR_W-1:0], 1'b0};
    assign pos_2      = {bus.in_index[PAIR_W-1:0], 1'b1};

    assign bus.comp_dout = buffer[{byte_idx, 3'b000} +: 8];
    assign bus.out_index = {{(8 - BYTE_W){1'b0}}, byte_idx};
    assign bus.err       = err_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs; dropping set returns to IDLE from anywhere
    always_comb begin
        state_nx       = state;
        bus.readin_ok  = 1'b0;
        bus.readout_ok = 1'b0;
        bus.done       = 1'b0;
        case (state)
            ST_IDLE: state_nx = ST_LOAD;
            ST_LOAD: begin
                bus.readin_ok = 1'b1;
                if (xfer && bus.full_in) state_nx = ST_OUT;
            end
            ST_OUT: begin
                bus.readout_ok = 1'b1;
                if (rd_xfer && last_byte) state_nx = ST_DONE;
            end
            ST_DONE: bus.done = 1'b1;
            default: state_nx = ST_IDLE;
        endcase
        if (!bus.set) state_nx = ST_IDLE;
    end

    // Bit buffer: cleared on LOAD entry, out-of-range pair indices are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buffer <= '0;
        end else if (load_entry) begin
            buffer <= '0;
        end else if (xfer && in_range) begin
            buffer[pos_1] <= bit_1;
            buffer[pos_2] <= bit_2;
        end
    end

    // Output byte pointer; holds on the last byte so DONE keeps a stable index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      byte_idx <= '0;
        else if (load_entry)             byte_idx <= '0;
        else if (rd_xfer && !last_byte)  byte_idx <= byte_idx + 1'b1;
    end

`ifdef COMPRESS1_RANGE_CHECK_EN
    // Sticky range error over every accepted coefficient, cleared on LOAD entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              err_q <= 1'b0;
        else if (load_entry)                     err_q <= 1'b0;
        else if (xfer && (range_1 || range_2))   err_q <= 1'b1;
    end
`else
    // Range flags are always low in this build
    logic unused_range;
    assign unused_range = range_1 ^ range_2;
    assign err_q        = 1'b0;
`endif

endmodule

// File: tb/tb_compress1.sv
// Self-checking bench for compress1: directed runs against a coefficient-level model.
module tb_compress1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    compress1_if bus();

    compress1 #(.N_COEF(256), .Q(3329)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         coef [256];
    logic [7:0] exp_b [32];
    logic [7:0] got [32];
    logic [7:0] rb [32];
    int         ptr;
    bit         chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // x compresses to 1 iff round(2x/3329) is odd
    function automatic bit cbit(input int x);
        return (x >= 833) && (x <= 2496);
    endfunction

    task automatic build_model();
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 8; j++)
                exp_b[k][j] = cbit(coef[8*k + j]);
    endtask

    // Compare process: every cycle a byte is offered it must be the next model byte
    always @(negedge clk) begin
        if (chk_en && reset) begin
            if (bus.readout_ok) begin
                if (ptr >= 32) begin
                    chk("extra_byte", ptr, 31);
                end else begin
                    chk("comp_dout", bus.comp_dout, exp_b[ptr]);
                    chk("out_index", bus.out_index, ptr);
                    got[ptr] = bus.comp_dout;
                    if (bus.readout) ptr++;
                end
            end
        end else begin
            ptr = 0;
        end
    end

    task automatic start_load();
        int n;
        for (int i = 0; i < 256; i++) coef[i] = 0;
        @(posedge clk); #1;
        bus.set = 1'b1;
        n = 0;
        while (!bus.readin_ok && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("load_entry", bus.readin_ok, 1);
    endtask

    task automatic beat(input int idx, input int d1, input int d2, input bit last);
        chk("readin_ok", bus.readin_ok, 1);
        chk("no_early_out", bus.readout_ok, 0);
        bus.readin     = 1'b1;
        bus.in_index   = idx[7:0];
        bus.comp_din_1 = d1[15:0];
        bus.comp_din_2 = d2[15:0];
        bus.full_in    = last;
        @(posedge clk); #1;
        bus.readin  = 1'b0;
        bus.full_in = 1'b0;
        if (idx < 128) begin
            coef[2*idx]     = d1;
            coef[2*idx + 1] = d2;
        end
    endtask

    task automatic drain(input bit stall);
        int n;
        build_model();
        chk_en = 1'b1;
        n = 0;
        while (!bus.done && n < 600) begin
            bus.readout = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        bus.readout = 1'b0;
        chk("done", bus.done, 1);
        chk("byte_count", ptr, 32);
        chk("readout_ok_in_done", bus.readout_ok, 0);
        @(posedge clk); #1;
        chk("done_held", bus.done, 1);
        chk_en = 1'b0;
        bus.set = 1'b0;
        @(posedge clk); #1;
        chk("done_cleared", bus.done, 0);
        chk("idle_readin_ok", bus.readin_ok, 0);
    endtask

    initial begin
        bus.set = 1'b0; bus.readin = 1'b0; bus.full_in = 1'b0;
        bus.comp_din_1 = '0; bus.comp_din_2 = '0; bus.in_index = '0; bus.readout = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_readin_ok", bus.readin_ok, 0);
        chk("rst_readout_ok", bus.readout_ok, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_comp_dout", bus.comp_dout, 0);
        chk("rst_out_index", bus.out_index, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // All-zero polynomial
        start_load();
        for (int i = 0; i < 128; i++) beat(i, 0, 0, i == 127);
        drain(1'b0);
        for (int k = 0; k < 32; k++) chk("zero_byte", got[k], 8'h00);
        chk("zero_err", bus.err, 0);

        // All coefficients 1665
        start_load();
        for (int i = 0; i < 128; i++) beat(i, 1665, 1665, i == 127);
        drain(1'b0);
        for (int k = 0; k < 32; k++) chk("ff_byte", got[k], 8'hFF);

        // Thresholds, discarded index, idle full_in, unwritten pairs, stalls
        start_load();
        bus.full_in = 1'b1;
        @(posedge clk); #1;
        bus.full_in = 1'b0;
        chk("full_in_no_xfer", bus.readin_ok, 1);
        beat(0, 832, 833, 1'b0);
        beat(1, 2496, 2497, 1'b0);
        beat(200, 1665, 1665, 1'b0);
        beat(5, 0, 0, 1'b1);
        build_model();
        chk("model_pin_b0", exp_b[0], 8'h06);
        drain(1'b1);
        chk("bnd_byte0", got[0], 8'h06);
        for (int k = 1; k < 32; k++) chk("bnd_cleared", got[k], 8'h00);

        // Round trip of random bytes through decompress1 with stalled readout
        start_load();
        for (int k = 0; k < 32; k++) rb[k] = 8'($urandom);
        for (int i = 0; i < 128; i++) begin
            int d1;
            int d2;
            logic [7:0] b;
            b  = rb[i/4];
            d1 = b[(2*i) % 8] ? 1665 : 0;
            d2 = b[(2*i + 1) % 8] ? 1665 : 0;
            beat(i, d1, d2, i == 127);
        end
        drain(1'b1);
        for (int k = 0; k < 32; k++) chk("roundtrip", got[k], rb[k]);

        // Reset mid-LOAD, then a full run of out-of-range coefficients
        start_load();
        for (int i = 0; i < 60; i++) beat(i, 3329, 3329, 1'b0);
        reset = 1'b0;
        #2;
        chk("mid_rst_readin_ok", bus.readin_ok, 0);
        chk("mid_rst_readout_ok", bus.readout_ok, 0);
        chk("mid_rst_err", bus.err, 0);
        chk("mid_rst_out_index", bus.out_index, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) coef[i] = 0;
        begin
            int n = 0;
            while (!bus.readin_ok && n < 10) begin
                chk("post_rst_no_out", bus.readout_ok, 0);
                @(posedge clk); #1;
                n++;
            end
            chk("post_rst_load", bus.readin_ok, 1);
        end
        for (int i = 0; i < 128; i++) beat(i, 3329, 3329, i == 127);
`ifdef COMPRESS1_RANGE_CHECK_EN
        chk("range_err", bus.err, 1);
`else
        chk("range_err", bus.err, 0);
`endif
        drain(1'b0);
        for (int k = 0; k < 32; k++) chk("over_q_byte", got[k], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/compress1.md
COMPRESS1 -- requirements
Module: compress1

Interface
REQ-001 Parameter N_COEF, default 256, coefficients per polynomial.
REQ-002 Parameter Q, default 3329, Kyber modulus.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 set  in  1  block enable; low holds block in IDLE.
REQ-006 readin  in  1  producer has a coefficient pair on comp_din_1/2.
REQ-007 full_in  in  1  marks current input beat as last of polynomial.
REQ-008 comp_din_1  in  16  coefficient 2*in_index.
REQ-009 comp_din_2  in  16  coefficient 2*in_index+1.
REQ-010 in_index  in  8  pair index 0..127.
REQ-011 readout  in  1  consumer accepts comp_dout this cycle.
REQ-012 readin_ok  out  1  block accepts an input pair this cycle.
REQ-013 comp_dout  out  8  compressed message byte.
REQ-014 out_index  out  8  byte index 0..31 of comp_dout.
REQ-015 readout_ok  out  1  comp_dout/out_index valid.
REQ-016 done  out  1  all 32 bytes delivered.
REQ-017 err  out  1  sticky out-of-range flag (see Configuration).

Function
REQ-018 Per coefficient x, bit = 1 iff 833 <= x <= 2496, else 0 (round(2x/Q) mod 2); x >= Q uses same comparison (yields 0).
REQ-019 States IDLE, LOAD, OUT, DONE; IDLE->LOAD when set=1; any state->IDLE next cycle when set=0.
REQ-020 LOAD: readin_ok=1; input transfer = readin & readin_ok; bits written to 256-bit buffer positions 2*in_index (din_1) and 2*in_index+1 (din_2).
REQ-021 Input beats with in_index >= 128 are accepted and discarded.
REQ-022 Transfer with full_in=1 -> OUT next cycle; full_in without transfer ignored.
REQ-023 Byte k = buffer bits [8k+7:8k], bit 0 = coefficient 8k (LSB-first, inverse of decompress1).
REQ-024 OUT: readin_ok=0; readout_ok=1 from first OUT cycle with out_index=0 and byte 0 on comp_dout.
REQ-025 readout & readout_ok advances to next byte next cycle; comp_dout/out_index held stable while readout=0.
REQ-026 Transfer of byte 31 -> DONE; readout_ok=0, done=1 held until set=0.
REQ-027 Buffer cleared on entry to LOAD; unwritten pairs compress as 0.
REQ-028 No input backpressure within LOAD: one pair per cycle sustained.

Reset
REQ-029 reset=0 asynchronously forces IDLE; readin_ok, readout_ok, done, err = 0; comp_dout, out_index = 0; buffer cleared.
REQ-030 Reset mid-LOAD or mid-OUT discards all partial data; no byte emitted after release until a new full LOAD.

Configuration
REQ-031 Macro COMPRESS1_RANGE_CHECK_EN defined: err set when any accepted coefficient >= Q, cleared only on reset or entry to LOAD.
REQ-032 Macro undefined: err tied 0, no comparison logic; compression result identical.

Structure
REQ-033 Shared package kyber_pkg holds KYBER_Q=3329, KYBER_N=256, thresholds 833/2496, state enum type.
REQ-034 Sub-module compress1_bit: combinational 16-bit coefficient -> 1 bit (plus range flag), instantiated twice.

Verification
REQ-035 Pairs all 0, full_in at index 127, readout=1 -> 32 bytes 0x00, out_index 0..31, done=1.
REQ-036 All coefficients 1665 -> 32 bytes 0xFF.
REQ-037 Boundaries: din_1=832, din_2=833 at index 0; din_1=2496, din_2=2497 at index 1 -> byte 0 = 0x06.
REQ-038 Round trip: 32 random bytes through decompress1 then compress1 -> identical bytes, same indices.
REQ-039 Random readout stalls -> comp_dout stable while stalled, no byte skipped or duplicated.
REQ-040 reset pulsed low at input beat 60, then full run with din=3329 -> readout_ok stays 0 before full_in, err=1 only with COMPRESS1_RANGE_CHECK_EN.
